xbar_rob_ch: RTL

Per-channel reorder buffer for the cross bar return path, generalised in bank count, data width, ROB depth and keep-order FIFO depth.
- Allocates a per-bank ROB tag when a channel read request is accepted.
- Collects out-of-order bank responses addressed to this channel.
- Returns data to the channel strictly in request order under a real valid/ready handshake.
- Sits between the bank response buses and one channel return port; one instance per channel.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/xbar_rob_bank_slots.sv | 69 ++++++
 rtl/xbar_rob_ch.sv | 97 +++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and types for the crossbar return path.
// Defaults here size the per-channel reorder buffer instances.
package xbar_pkg;

    localparam int NUM_BANKS = 4;
    localparam int CH_W      = 2;
    localparam int DW        = 128;
    localparam int ROB_DEPTH = 8;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int ROB_W     = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   ch_id;
        logic [ROB_W-1:0]  rob_num;
        logic [DW-1:0]     data;
    } bank_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout_o presents the oldest entry while not empty.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign dout_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/xbar_rob_bank_slots.sv
// Reorder slots for one bank: tag allocation, out-of-order fill, in-order release.
// A write into an already-valid slot is dropped and latches a sticky error.
module xbar_rob_bank_slots
    import xbar_pkg::*;
#(
    parameter int DW        = xbar_pkg::DW,
    parameter int ROB_DEPTH = xbar_pkg::ROB_DEPTH,
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic             wr_en_i,
    input  logic [ROB_W-1:0] wr_tag_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             pop_i,
    output logic [ROB_W-1:0] alloc_tag_o,
    output logic             full_o,
    output logic             head_valid_o,
    output logic [DW-1:0]    head_data_o,
    output logic             err_o
);

    logic [DW-1:0]        slot_data [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] slot_valid;
    logic [ROB_DEPTH-1:0] slot_valid_n;
    logic [ROB_W-1:0]     alloc_ptr;
    logic [ROB_W-1:0]     rd_ptr;
    logic [ROB_W:0]       outstanding;
    logic                 wr_ok;

    assign wr_ok        = wr_en_i & ~slot_valid[wr_tag_i];
    assign alloc_tag_o  = alloc_ptr;
    assign full_o       = (outstanding == (ROB_W+1)'(ROB_DEPTH));
    assign head_valid_o = slot_valid[rd_ptr];
    assign head_data_o  = slot_data[rd_ptr];

    // A successful write never targets the slot being released, since that one is valid.
    always_comb begin
        slot_valid_n = slot_valid;
        if (pop_i) slot_valid_n[rd_ptr] = 1'b0;
        if (wr_ok) slot_valid_n[wr_tag_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid  <= '0;
            alloc_ptr   <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_o       <= 1'b0;
        end else begin
            slot_valid <= slot_valid_n;
            if (alloc_i) alloc_ptr <= alloc_ptr + 1'b1;
            if (pop_i)   rd_ptr    <= rd_ptr + 1'b1;
            case ({alloc_i, pop_i})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (wr_en_i && !wr_ok) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) slot_data[wr_tag_i] <= wr_data_i;
    end

endmodule

// File: rtl/xbar_rob_ch.sv
// Per-channel reorder buffer: per-bank slot arrays plus a keep-order FIFO of bank ids
// so bank responses return to the channel strictly in request order.
module xbar_rob_ch
    import xbar_pkg::*;
#(
    parameter int CHANNEL_ID = 0,
    parameter int NUM_BANKS  = xbar_pkg::NUM_BANKS,
    parameter int BANK_W     = $clog2(NUM_BANKS),
    parameter int CH_W       = xbar_pkg::CH_W,
    parameter int DW         = xbar_pkg::DW,
    parameter int ROB_DEPTH  = xbar_pkg::ROB_DEPTH,
    parameter int ROB_W      = $clog2(ROB_DEPTH),
    parameter int KOF_AW     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    input  logic [BANK_W-1:0]          req_bank_id_i,
    output logic                       req_ready_o,
    output logic [ROB_W-1:0]           req_rob_num_o,
    input  logic [NUM_BANKS-1:0]       bank_rsp_valid_i,
    input  logic [NUM_BANKS*CH_W-1:0]  bank_rsp_ch_id_i,
    input  logic [NUM_BANKS*ROB_W-1:0] bank_rsp_rob_num_i,
    input  logic [NUM_BANKS*DW-1:0]    bank_rsp_data_i,
    output logic                       rtn_valid_o,
    input  logic                       rtn_ready_i,
    output logic [DW-1:0]              rtn_data_o,
    output logic [BANK_W-1:0]          rtn_bank_id_o,
    output logic [NUM_BANKS-1:0]       bank_pop_o,
    output logic                       err_o
);

    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_head_valid;
    logic [NUM_BANKS-1:0] bank_err;
    logic [ROB_W-1:0]     bank_alloc_tag [NUM_BANKS];
    logic [DW-1:0]        bank_head_data [NUM_BANKS];

    logic [BANK_W-1:0]    head;
    logic                 kof_empty;
    logic                 kof_full;
    logic                 acc;
    logic                 fire;

    // Ready ignores the return side, so a full KOF blocks a push even when a pop is firing.
    assign req_ready_o   = ~kof_full & ~bank_full[req_bank_id_i];
    assign req_rob_num_o = bank_alloc_tag[req_bank_id_i];
    assign acc           = req_valid_i & req_ready_o;

    assign rtn_valid_o   = ~kof_empty & bank_head_valid[head];
    assign fire          = rtn_valid_o & rtn_ready_i;
    assign rtn_data_o    = rtn_valid_o ? bank_head_data[head] : '0;
    assign rtn_bank_id_o = rtn_valid_o ? head : '0;
    assign bank_pop_o    = fire ? (NUM_BANKS'(1) << head) : '0;
    assign err_o         = |bank_err;

    sync_fifo #(
        .DW (BANK_W),
        .AW (KOF_AW)
    ) u_kof (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (acc),
        .din_i   (req_bank_id_i),
        .pop_i   (fire),
        .dout_o  (head),
        .empty_o (kof_empty),
        .full_o  (kof_full)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic wr_en;

        assign wr_en = bank_rsp_valid_i[b] &
                       (bank_rsp_ch_id_i[b*CH_W +: CH_W] == CH_W'(CHANNEL_ID));

        xbar_rob_bank_slots #(
            .DW        (DW),
            .ROB_DEPTH (ROB_DEPTH),
            .ROB_W     (ROB_W)
        ) u_slots (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .alloc_i      (acc & (req_bank_id_i == BANK_W'(b))),
            .wr_en_i      (wr_en),
            .wr_tag_i     (bank_rsp_rob_num_i[b*ROB_W +: ROB_W]),
            .wr_data_i    (bank_rsp_data_i[b*DW +: DW]),
            .pop_i        (fire & (head == BANK_W'(b))),
            .alloc_tag_o  (bank_alloc_tag[b]),
            .full_o       (bank_full[b]),
            .head_valid_o (bank_head_valid[b]),
            .head_data_o  (bank_head_data[b]),
            .err_o        (bank_err[b])
        );
    end

endmodule
